round_sat_pipe: RTL and testbench



---
 rtl/round_sat_pipe.sv | 128 ++++++++++++
 tb/tb_round_sat_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sat_pipe.sv
// Two-stage signed round-and-saturate pipeline with req/ack handshake on both sides.
// S1 holds the rounded value at W_IN+1 bits; S2 holds the saturated output and its clip flag.
module round_sat_pipe #(
    parameter int W_IN        = 20,
    parameter int W_OUT       = 16,
    parameter int SHIFT_WIDTH = 4,
    parameter int SYM_SAT     = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W_IN-1:0]        t_0_dat,
    input  logic                   t_0_req,
    output logic                   t_0_ack,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [1:0]             mode,
    output logic [W_OUT-1:0]       i_0_dat,
    output logic                   i_0_sat,
    output logic                   i_0_req,
    input  logic                   i_0_ack,
    input  logic                   cnt_clr,
    output logic [CNT_WIDTH-1:0]   sat_cnt
);

    localparam int WR = W_IN + 1;
    localparam logic signed [WR-1:0] MAXV =
        {{(W_IN - W_OUT + 2){1'b0}}, {(W_OUT - 1){1'b1}}};
    localparam logic signed [WR-1:0] MINV_FULL =
        {{(W_IN - W_OUT + 2){1'b1}}, {(W_OUT - 1){1'b0}}};
    localparam logic signed [WR-1:0] MINV = (SYM_SAT != 0) ? -MAXV : MINV_FULL;

    // Valid/ready: a beat moves on a side when req and ack are both high at a
    // rising clk edge; a stage loads whenever it is empty or its content leaves.
    logic s2_adv, s1_adv, accept;

    logic                   s1_valid_q, s1_valid_d;
    logic signed [WR-1:0]   s1_r_q, s1_r_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [W_OUT-1:0]       s2_dat_q, s2_dat_d;
    logic                   s2_sat_q, s2_sat_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic signed [WR-1:0] x_ext, frac_mask, half, frac;
    logic signed [WR-1:0] trunc_r, up_r, away_r, round_r;
    logic [W_OUT-1:0]     sat_dat;
    logic                 sat_flag;

    always_comb begin
        s2_adv = ~s2_valid_q | i_0_ack;
        s1_adv = ~s1_valid_q | s2_adv;
        accept = t_0_req & s1_adv;
    end

    // half = 2^(s-1) is the top bit of the fraction mask; mask>>1 is half-1.
    always_comb begin
        x_ext     = {t_0_dat[W_IN-1], t_0_dat};
        frac_mask = '0;
        for (int i = 0; i < WR; i++) begin
            frac_mask[i] = (i < int'(shift));
        end
        half    = frac_mask & ~(frac_mask >> 1);
        frac    = x_ext & frac_mask;
        trunc_r = x_ext >>> shift;
        up_r    = (x_ext + half) >>> shift;
        away_r  = (x_ext + (frac_mask >> 1)) >>> shift;
        case (mode)
            2'd0:    round_r = trunc_r;
            2'd1:    round_r = up_r;
            2'd2:    round_r = ((frac == half) && !trunc_r[0]) ? trunc_r : up_r;
            default: round_r = x_ext[WR-1] ? away_r : up_r;
        endcase
    end

    always_comb begin
        sat_dat  = s1_r_q[W_OUT-1:0];
        sat_flag = 1'b0;
        if (s1_r_q > MAXV) begin
            sat_dat  = MAXV[W_OUT-1:0];
            sat_flag = 1'b1;
        end else if (s1_r_q < MINV) begin
            sat_dat  = MINV[W_OUT-1:0];
            sat_flag = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_adv ? accept : s1_valid_q;
        s1_r_d     = accept ? round_r : s1_r_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_dat_d   = s2_dat_q;
        s2_sat_d   = s2_sat_q;
        if (s2_adv && s1_valid_q) begin
            s2_dat_d = sat_dat;
            s2_sat_d = sat_flag;
        end
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q && i_0_ack && s2_sat_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_dat_q   <= '0;
            s2_sat_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_dat_q   <= s2_dat_d;
            s2_sat_q   <= s2_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign t_0_ack = s1_adv;
    assign i_0_req = s2_valid_q;
    assign i_0_dat = s2_dat_q;
    assign i_0_sat = s2_sat_q;
    assign sat_cnt = cnt_q;

endmodule

// File: tb/tb_round_sat_pipe.sv
// Bench for round_sat_pipe: a default instance and a symmetric-clip, 2-bit-counter
// instance share the stimulus; an integer-arithmetic model feeds per-instance queues.
module tb_round_sat_pipe;

    localparam int W_IN  = 20;
    localparam int W_OUT = 16;
    localparam int SW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [W_IN-1:0]   t_0_dat;
    logic              t_0_req;
    logic [SW-1:0]     shift;
    logic [1:0]        mode;
    logic              i_0_ack;
    logic              cnt_clr;

    logic              t_0_ack, i_0_req, i_0_sat;
    logic [W_OUT-1:0]  i_0_dat;
    logic [15:0]       sat_cnt;
    logic              sym_t_ack, sym_req, sym_sat;
    logic [W_OUT-1:0]  sym_dat;
    logic [1:0]        sym_cnt;

    int checks = 0;
    int errors = 0;
    logic [W_OUT:0] exp_q[$];
    logic [W_OUT:0] exp_sym_q[$];
    longint exp_cnt = 0;
    longint exp_cnt_sym = 0;

    always #5 clk = ~clk;

    round_sat_pipe #(.W_IN(W_IN), .W_OUT(W_OUT), .SHIFT_WIDTH(SW), .SYM_SAT(0), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .t_0_dat(t_0_dat), .t_0_req(t_0_req), .t_0_ack(t_0_ack),
        .shift(shift), .mode(mode), .i_0_dat(i_0_dat), .i_0_sat(i_0_sat), .i_0_req(i_0_req),
        .i_0_ack(i_0_ack), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt));

    round_sat_pipe #(.W_IN(W_IN), .W_OUT(W_OUT), .SHIFT_WIDTH(SW), .SYM_SAT(1), .CNT_WIDTH(2)) u_sym (
        .clk(clk), .reset(reset), .t_0_dat(t_0_dat), .t_0_req(t_0_req), .t_0_ack(sym_t_ack),
        .shift(shift), .mode(mode), .i_0_dat(sym_dat), .i_0_sat(sym_sat), .i_0_req(sym_req),
        .i_0_ack(i_0_ack), .cnt_clr(cnt_clr), .sat_cnt(sym_cnt));

    // ---------------- reference model ----------------
    function automatic longint floor_div(longint a, longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint round_ref(longint x, int s, int m);
        longint d, h, t, f;
        if (s == 0) return x;
        d = longint'(1) << s;
        h = d / 2;
        t = floor_div(x, d);
        f = x - t * d;
        case (m)
            0: return t;
            1: return floor_div(x + h, d);
            2: return ((f == h) && (t % 2 == 0)) ? t : floor_div(x + h, d);
            default: return (x >= 0) ? floor_div(x + h, d) : floor_div(x + h - 1, d);
        endcase
    endfunction

    function automatic logic [W_OUT:0] sat_ref(longint r, bit sym);
        longint maxv, minv;
        logic [W_OUT-1:0] lo;
        maxv = (longint'(1) << (W_OUT - 1)) - 1;
        minv = sym ? -maxv : -maxv - 1;
        if (r > maxv) begin
            lo = W_OUT'(maxv);
            return {1'b1, lo};
        end
        if (r < minv) begin
            lo = W_OUT'(minv);
            return {1'b1, lo};
        end
        lo = W_OUT'(r);
        return {1'b0, lo};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W_OUT:0] e;
        bit del_sat, del_sat_sym;
        longint x, r;
        if (!reset) begin
            chk("sat_cnt", sat_cnt, exp_cnt);
            chk("sat_cnt_sym", sym_cnt, exp_cnt_sym);
            del_sat = 1'b0;
            del_sat_sym = 1'b0;
            if (i_0_req && i_0_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {i_0_sat, i_0_dat}, -1);
                end else begin
                    e = exp_q.pop_front();
                    del_sat = e[W_OUT];
                    chk("out_beat", {i_0_sat, i_0_dat}, e);
                end
            end
            if (sym_req && i_0_ack) begin
                if (exp_sym_q.size() == 0) begin
                    chk("unexpected_beat_sym", {sym_sat, sym_dat}, -1);
                end else begin
                    e = exp_sym_q.pop_front();
                    del_sat_sym = e[W_OUT];
                    chk("out_beat_sym", {sym_sat, sym_dat}, e);
                end
            end
            if (cnt_clr) exp_cnt = 0;
            else if (del_sat && exp_cnt < 65535) exp_cnt++;
            if (cnt_clr) exp_cnt_sym = 0;
            else if (del_sat_sym && exp_cnt_sym < 3) exp_cnt_sym++;
            x = longint'($signed(t_0_dat));
            r = round_ref(x, int'(shift), int'(mode));
            if (t_0_req && t_0_ack) exp_q.push_back(sat_ref(r, 1'b0));
            if (t_0_req && sym_t_ack) exp_sym_q.push_back(sat_ref(r, 1'b1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int x, input int s, input int m);
        int n;
        t_0_dat = W_IN'(x);
        shift = SW'(s);
        mode = 2'(m);
        t_0_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!t_0_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!t_0_ack) fail_timeout("send_beat");
        @(posedge clk);
        #1;
        t_0_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        i_0_ack = 1'b1;
        t_0_req = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || exp_sym_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail_timeout("drain");
    endtask

    int dx[20] = '{24, 24, 24, 24, 40, 40, 40, 40, -40, -40, -40, -40,
                   32768, -32769, -32768, 524280, 524280, -524288, 524287, 7};
    int ds[20] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0, 0, 0, 4, 4, 3, 0, 1};
    int dm[20] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 1, 0, 3, 2, 2};

    initial begin
        int idx, acc_n, req_n, n;
        reset = 1'b1;
        t_0_req = 1'b0;
        t_0_dat = '0;
        shift = '0;
        mode = '0;
        i_0_ack = 1'b1;
        cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", i_0_req, 0);
        chk("reset_dat", i_0_dat, 0);
        chk("reset_sat", i_0_sat, 0);
        chk("reset_cnt", sat_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_t_ack", t_0_ack, 1);
        @(posedge clk);
        #1;

        // directed rounding and saturation vectors
        for (int i = 0; i < 20; i++) send_beat(dx[i], ds[i], dm[i]);
        drain();

        // continuous ramp with a 5-cycle output stall
        idx = 0;
        acc_n = -1;
        req_n = -1;
        n = 0;
        while ((idx < 32 || exp_q.size() != 0) && n < 300) begin
            t_0_req = (idx < 32);
            t_0_dat = W_IN'(idx);
            shift = '0;
            mode = '0;
            i_0_ack = !(n >= 3 && n < 8);
            @(negedge clk);
            if (n == 7) chk("stall_t_0_ack", t_0_ack, 0);
            if (t_0_req && t_0_ack) begin
                if (acc_n < 0) acc_n = n;
                idx++;
            end
            if (i_0_req && req_n < 0) req_n = n;
            @(posedge clk);
            #1;
            n++;
        end
        t_0_req = 1'b0;
        i_0_ack = 1'b1;
        if (n >= 300) fail_timeout("ramp");
        chk("ramp_accepted", idx, 32);
        chk("ramp_latency", req_n - acc_n, 2);
        drain();

        // saturation counter
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        repeat (3) send_beat(32768, 0, 0);
        drain();
        @(negedge clk);
        chk("cnt_three", sat_cnt, 3);
        @(posedge clk);
        #1;
        i_0_ack = 1'b0;
        send_beat(-32769, 0, 0);
        n = 0;
        @(negedge clk);
        while (!i_0_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!i_0_req) fail_timeout("cnt_wait_req");
        @(posedge clk);
        #1;
        i_0_ack = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins", sat_cnt, 0);
        @(posedge clk);
        #1;
        repeat (5) send_beat(40000, 0, 1);
        drain();
        @(negedge clk);
        chk("cnt_five", sat_cnt, 5);
        chk("cnt_sym_stick", sym_cnt, 3);
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure and clears
        for (int k = 0; k < 600; k++) begin
            t_0_req = ($urandom_range(0, 3) != 0);
            t_0_dat = W_IN'($urandom_range(0, (1 << W_IN) - 1));
            shift = SW'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
            i_0_ack = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            #1;
        end
        cnt_clr = 1'b0;
        drain();

        // reset with both stages full and output stalled
        send_beat(32768, 0, 0);
        drain();
        i_0_ack = 1'b0;
        send_beat(32768, 0, 0);
        send_beat(-40000, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_req", i_0_req, 0);
        chk("midrst_dat", i_0_dat, 0);
        chk("midrst_sat", i_0_sat, 0);
        chk("midrst_cnt", sat_cnt, 0);
        chk("midrst_req_sym", sym_req, 0);
        exp_q.delete();
        exp_sym_q.delete();
        exp_cnt = 0;
        exp_cnt_sym = 0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        i_0_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_idle", i_0_req, 0);
        end
        @(posedge clk);
        #1;
        send_beat(40, 4, 2);
        send_beat(-40, 4, 3);
        send_beat(-32769, 0, 0);
        drain();
        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size() + exp_sym_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
